// File: rtl/spwm_multiphase_dt.sv
// Multiphase sine-triangle PWM generator with per-leg dead time, fault latch and enable gating.
// Shared phase accumulator and sine LUT feed N_PH reference pipelines compared against one carrier.
module spwm_multiphase_dt #(
  parameter int CNT_W       = 12,
  parameter int CARRIER_MAX = 2500,
  parameter int N_PH        = 3,
  parameter int ACC_W       = 32,
  parameter int LUT_AW      = 8,
  parameter int DT_W        = 8,
  parameter int DT_CYC      = 50
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   fault,
  input  logic [ACC_W-1:0]       freq_word,
  input  logic [CNT_W-2:0]       mod_index,
  output logic [CNT_W-1:0]       carrier_out,
  output logic [N_PH*CNT_W-1:0]  ref_out,
  output logic                   sync_pulse,
  output logic [N_PH-1:0]        drv_hi,
  output logic [N_PH-1:0]        drv_lo,
  output logic                   running,
  output logic                   fault_latched
);

  typedef enum logic [1:0] {ST_DEAD = 2'd0, ST_HI = 2'd1, ST_LO = 2'd2} leg_state_e;

  localparam int  LUT_N   = 1 << LUT_AW;
  localparam int  PH_STEP = LUT_N / N_PH;
  localparam real PI      = 3.14159265358979323846;
  localparam real AMP     = real'((1 << (CNT_W - 1)) - 1);

  localparam logic [CNT_W-1:0]          CMAX    = CNT_W'(CARRIER_MAX);
  localparam logic [CNT_W-1:0]          HALF    = CNT_W'(CARRIER_MAX / 2);
  localparam logic signed [2*CNT_W-1:0] CMAX_X  = (2*CNT_W)'(CARRIER_MAX);
  localparam logic signed [2*CNT_W-1:0] HALF_X  = (2*CNT_W)'(CARRIER_MAX / 2);
  localparam logic [DT_W-1:0]           DT_LAST = DT_W'(DT_CYC - 1);

  logic             w_fault_nxt;
  logic             w_run_nxt;
  logic             w_active;
  logic             w_sync;
  logic             r_fault_latched;
  logic             r_running;
  logic             r_up;
  logic [CNT_W-1:0] r_carrier;
  logic [CNT_W-1:0] w_m;
  logic [CNT_W-1:0] r_m;
  logic [ACC_W-1:0] r_acc;

  // A latched fault holds until a cycle with en low and fault low; it overrides en.
  assign w_fault_nxt = fault | (r_fault_latched & en);
  assign w_run_nxt   = en & ~w_fault_nxt;
  // Stepping needs both the present and the next run state, so a rising edge restarts from 0.
  assign w_active    = w_run_nxt & r_running;
  assign w_sync      = r_running & (r_carrier == '0);
  assign w_m         = ({1'b0, mod_index} > HALF) ? HALF : {1'b0, mod_index};

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_latched <= 1'b0;
      r_running       <= 1'b0;
      r_m             <= '0;
    end else begin
      r_fault_latched <= w_fault_nxt;
      r_running       <= w_run_nxt;
      r_m             <= w_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carrier <= '0;
      r_up      <= 1'b1;
      r_acc     <= '0;
    end else if (!w_active) begin
      r_carrier <= '0;
      r_up      <= 1'b1;
      r_acc     <= '0;
    end else begin
      r_acc <= r_acc + freq_word;
      if (r_up) begin
        r_carrier <= r_carrier + CNT_W'(1);
        if (r_carrier == CMAX - CNT_W'(1)) r_up <= 1'b0;
      end else begin
        r_carrier <= r_carrier - CNT_W'(1);
        if (r_carrier == CNT_W'(1)) r_up <= 1'b1;
      end
    end
  end

  assign carrier_out   = r_carrier;
  assign sync_pulse    = w_sync;
  assign running       = r_running;
  assign fault_latched = r_fault_latched;

  // Full-wave sine table built at elaboration, rounded half away from zero.
  logic signed [CNT_W-1:0] w_lut [LUT_N];
  for (genvar a = 0; a < LUT_N; a++) begin : g_lut
    localparam real X = AMP * $sin(2.0 * PI * real'(a) / real'(LUT_N));
    localparam int  V = (X >= 0.0) ? $rtoi(X + 0.5) : -$rtoi(0.5 - X);
    assign w_lut[a] = CNT_W'(V);
  end

  for (genvar p = 0; p < N_PH; p++) begin : g_ph
    logic [LUT_AW-1:0]          w_addr;
    logic signed [2*CNT_W-1:0]  w_prod;
    logic signed [2*CNT_W-1:0]  w_sum;
    logic [CNT_W-1:0]           w_clamp;
    logic signed [CNT_W-1:0]    r_sin;
    logic signed [2*CNT_W-1:0]  r_prod;
    logic [CNT_W-1:0]           r_ref_pipe;
    logic [CNT_W-1:0]           r_ref;
    logic                       r_raw;
    leg_state_e                 r_state;
    leg_state_e                 w_state_nxt;
    logic [DT_W-1:0]            r_cnt;
    logic [DT_W-1:0]            w_cnt_nxt;

    assign w_addr = r_acc[ACC_W-1 -: LUT_AW] + LUT_AW'(p * PH_STEP);
    assign w_prod = $signed({{CNT_W{r_sin[CNT_W-1]}}, r_sin} * {{CNT_W{1'b0}}, r_m});
    assign w_sum  = (r_prod >>> (CNT_W - 1)) + HALF_X;

    always_comb begin
      w_clamp = w_sum[CNT_W-1:0];
      if (w_sum[2*CNT_W-1])  w_clamp = '0;
      else if (w_sum > CMAX_X) w_clamp = CMAX;
    end

    // Three-stage reference pipeline; the visible reference only reloads at the valley.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sin      <= '0;
        r_prod     <= '0;
        r_ref_pipe <= '0;
        r_ref      <= '0;
        r_raw      <= 1'b0;
      end else begin
        r_sin      <= w_lut[w_addr];
        r_prod     <= w_prod;
        r_ref_pipe <= w_clamp;
        if (w_sync) r_ref <= r_ref_pipe;
        r_raw      <= (r_ref > r_carrier);
      end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!w_active) begin
        w_state_nxt = ST_DEAD;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          ST_HI: if (!r_raw) begin
            w_state_nxt = ST_DEAD;
            w_cnt_nxt   = '0;
          end
          ST_LO: if (r_raw) begin
            w_state_nxt = ST_DEAD;
            w_cnt_nxt   = '0;
          end
          default: begin
            if (r_cnt == DT_LAST) w_state_nxt = r_raw ? ST_HI : ST_LO;
            else                  w_cnt_nxt   = r_cnt + DT_W'(1);
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_DEAD;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    assign drv_hi[p]                   = (r_state == ST_HI);
    assign drv_lo[p]                   = (r_state == ST_LO);
    assign ref_out[p*CNT_W +: CNT_W]   = r_ref;
  end

endmodule

// File: doc/spwm_multiphase_dt.md
Name: spwm_multiphase_dt

Overview:
- Parametrised successor to the team's two-driver PWM controller.
- Generates a symmetric triangular carrier and N_PH sinusoidal references. References come from a shared phase accumulator and sine LUT, with equal phase offsets between phases.
- Compares each reference against the carrier and drives complementary high/low gate outputs per leg, with programmable dead time.
- Fault latching and enable gating are included. Sits between the switch/control logic and the GPIO gate-driver pins of the frequency inverter.

Parameters:
- CNT_W, 12, carrier/reference width in bits.
- CARRIER_MAX, 2500, carrier peak. Carrier period = 2*CARRIER_MAX clk cycles (10 kHz at 50 MHz). Must be even and < 2^CNT_W.
- N_PH, 3, number of phase legs (1..6).
- ACC_W, 32, phase accumulator width.
- LUT_AW, 8, sine LUT address width (2^LUT_AW entries, full wave).
- DT_W, 8, dead-time counter width.
- DT_CYC, 50, dead time in clk cycles (1 us at 50 MHz). Must be ≥ 1 and < 2^DT_W.

Ports:
- clk, input, 1, system clock (50 MHz).
- rst_n, input, 1, reset, asynchronous, active-low.
- en, input, 1, run enable (synchronous, level).
- fault, input, 1, external fault (synchronous, level); latched internally.
- freq_word, input, ACC_W, phase increment added to the accumulator every clk.
- mod_index, input, CNT_W-1, amplitude. Saturated internally to CARRIER_MAX/2.
- carrier_out, output, CNT_W, current carrier value.
- ref_out, output, N_PH*CNT_W, active references; phase p occupies bits [p*CNT_W +: CNT_W].
- sync_pulse, output, 1, high for exactly the cycle in which carrier_out == 0 while running.
- drv_hi, output, N_PH, high-side gate per leg.
- drv_lo, output, N_PH, low-side gate per leg.
- running, output, 1, high while enabled and no fault latched.
- fault_latched, output, 1, sticky fault flag.

Behaviour:
- Reset (rst_n low, async): all outputs 0; carrier 0 counting up; accumulator 0; refs 0; all legs in DEAD with counter 0.
- running = en & ~fault_latched, registered. running low ⇒ carrier/accumulator held at 0, sync_pulse 0, drv_hi/drv_lo 0 from the next clk.
- Fault latching:
  - fault high sets fault_latched on the next clk.
  - fault_latched clears only on a clk where en=0 and fault=0.
  - fault_latched has priority over en.
- Restart (running rising edge): carrier restarts from 0 counting up; accumulator restarts from 0; every leg enters DEAD with its counter cleared.
- Carrier:
  - Up/down counter 0→CARRIER_MAX→0. Turns at CARRIER_MAX (one cycle at peak) and at 0 (one cycle at valley).
  - Sequence for CARRIER_MAX=4: 0,1,2,3,4,3,2,1,0,1,…
- Phase accumulator: acc <= acc + freq_word each running cycle, wrapping modulo 2^ACC_W.
- Phase address: addr_p = acc[ACC_W-1 -: LUT_AW] + p*floor(2^LUT_AW/N_PH), modulo 2^LUT_AW.
- Sine LUT: signed CNT_W values s = round((2^(CNT_W-1)-1)*sin(2π·addr/2^LUT_AW)).
- Reference computation:
  - ref_p = CARRIER_MAX/2 + ((s * m) >>> (CNT_W-1)), arithmetic shift, where m = min(mod_index, CARRIER_MAX/2).
  - Result clamped to [0, CARRIER_MAX].
  - Pipeline of at most 3 clk.
- Reference update: ref_out loads the pipelined values only in the cycle sync_pulse is high (double-buffered). Between valleys, refs are constant.
- Compare: raw_p registered = (ref_p > carrier), one clk after carrier_out.
- Leg FSM, per phase, states HI, LO, DEAD:
  - HI: drv_hi=1, drv_lo=0. If raw_p=0, go to DEAD, clear counter.
  - LO: drv_hi=0, drv_lo=1. If raw_p=1, go to DEAD, clear counter.
  - DEAD: both outputs 0; counter increments each clk. When counter == DT_CYC-1, go to HI if raw_p=1, else LO (outputs assert the following clk).
  - If raw_p toggles while in DEAD, the counter is not restarted; the decision uses raw_p at expiry.
  - Invariant: drv_hi & drv_lo is never 1 on any leg in any cycle. Each turn-on is preceded by ≥ DT_CYC cycles with both low.
- Boundary cases:
  - ref = 0 ⇒ leg stays LO.
  - ref = CARRIER_MAX ⇒ HI except at the carrier peak cycle, where raw_p=0.
  - Pulse narrower than DT_CYC ⇒ leg may remain in DEAD; no glitch output.
- freq_word and mod_index may change at any time. The effect appears at the next valley.

Test Plan:
- Reset/idle: rst_n=0 then 1 with en=0 → all outputs 0, carrier_out=0, sync_pulse never high.
- Carrier: CARRIER_MAX=8, en=1 → carrier 0..8..0, period 16 cycles; sync_pulse once per 16 cycles, at carrier 0.
- Zero modulation: mod_index=0, freq_word arbitrary → all ref_p=CARRIER_MAX/2; each leg HI for ≈CARRIER_MAX-DT_CYC cycles per period; drv_hi and drv_lo each low for exactly DT_CYC cycles around each transition.
- Dead time: DT_CYC=4, toggle ref across carrier → every drv turn-on preceded by ≥4 cycles with both low; assert drv_hi&drv_lo==0 always.
- Phase offset: freq_word=2^(ACC_W-LUT_AW), mod_index=CARRIER_MAX/2, N_PH=3 → refs follow LUT with addr offsets 85 and 170; ref_out changes only at sync_pulse.
- Fault: assert fault mid-period → next clk all drv 0, fault_latched=1, running=0. Deassert fault with en=1 → stays latched. en=0 then en=1 → restart, legs DEAD for DT_CYC before first turn-on.
